// File: rtl/ddr_rd_demux.sv
// DDR read-path write-back stage: takes a burst descriptor, then scatters each
// 16-byte read beat byte-per-bank across the SRAM banks and pulses done at the end.
module ddr_rd_demux #(
    parameter int NUM_BANKS = 16,
    parameter int ADDR_W    = 19,
    parameter int LEN_W     = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [ADDR_W-1:0]           base_addr,
    input  logic [LEN_W-1:0]            len_beats,
    input  logic [3:0]                  num_last_valid,
    input  logic                        last_in,
    input  logic                        ddr_rvalid,
    input  logic [8*NUM_BANKS-1:0]      ddr_rdata,
    output logic                        ddr_rready,
    output logic [NUM_BANKS-1:0]        sram_we,
    output logic [NUM_BANKS*ADDR_W-1:0] sram_addr,
    output logic [NUM_BANKS*8-1:0]      sram_wdata,
    output logic                        busy,
    output logic                        done,
    output logic                        done_last
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RECV  = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    // Lanes 0..nlv are valid in the final beat.
    function automatic logic [NUM_BANKS-1:0] lane_mask(input logic [3:0] nlv);
        logic [NUM_BANKS-1:0] m;
        m = '0;
        for (int i = 0; i < NUM_BANKS; i++) begin
            m[i] = (i <= int'(nlv));
        end
        return m;
    endfunction

    state_t                      state_q, state_d;
    logic [ADDR_W-1:0]           base_q, base_d;
    logic [LEN_W-1:0]            lenm1_q, lenm1_d;
    logic [3:0]                  nlv_q, nlv_d;
    logic                        last_q, last_d;
    logic [LEN_W-1:0]            beat_cnt_q, beat_cnt_d;
    logic                        rready_q, rready_d;
    logic [NUM_BANKS-1:0]        we_q, we_d;
    logic [NUM_BANKS*ADDR_W-1:0] addr_q, addr_d;
    logic [NUM_BANKS*8-1:0]      wdata_q, wdata_d;
    logic                        busy_q, busy_d;
    logic                        done_q, done_d;
    logic                        done_last_q, done_last_d;

    logic                        accept_s;
    logic                        final_s;
    logic [ADDR_W-1:0]           beat_addr_s;

    assign accept_s    = ddr_rvalid && rready_q;
    assign final_s     = (beat_cnt_q == lenm1_q);
    assign beat_addr_s = base_q + ADDR_W'(beat_cnt_q);

    // Next-state and next-output computation for the burst sequencer.
    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        lenm1_d     = lenm1_q;
        nlv_d       = nlv_q;
        last_d      = last_q;
        beat_cnt_d  = beat_cnt_q;
        rready_d    = rready_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        busy_d      = busy_q;
        we_d        = '0;
        done_d      = 1'b0;
        done_last_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_RECV;
                    base_d     = base_addr;
                    lenm1_d    = (len_beats == '0) ? '0 : (len_beats - LEN_W'(1));
                    nlv_d      = num_last_valid;
                    last_d     = last_in;
                    beat_cnt_d = '0;
                    rready_d   = 1'b1;
                    busy_d     = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RECV: begin
                if (accept_s) begin
                    addr_d  = {NUM_BANKS{beat_addr_s}};
                    wdata_d = ddr_rdata;
                    if (final_s) begin
                        we_d        = lane_mask(nlv_q);
                        state_d     = ST_FLUSH;
                        rready_d    = 1'b0;
                        done_d      = 1'b1;
                        done_last_d = last_q;
                    end else begin
                        we_d       = '1;
                        beat_cnt_d = beat_cnt_q + LEN_W'(1);
                    end
                end else begin
                    state_d = ST_RECV;
                end
            end
            ST_FLUSH: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d  = ST_IDLE;
                rready_d = 1'b0;
                busy_d   = 1'b0;
            end
        endcase
    end

    // State and registered-output update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            base_q      <= '0;
            lenm1_q     <= '0;
            nlv_q       <= 4'd0;
            last_q      <= 1'b0;
            beat_cnt_q  <= '0;
            rready_q    <= 1'b0;
            we_q        <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            done_last_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            lenm1_q     <= lenm1_d;
            nlv_q       <= nlv_d;
            last_q      <= last_d;
            beat_cnt_q  <= beat_cnt_d;
            rready_q    <= rready_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            done_last_q <= done_last_d;
        end
    end

    assign ddr_rready = rready_q;
    assign sram_we    = we_q;
    assign sram_addr  = addr_q;
    assign sram_wdata = wdata_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign done_last  = done_last_q;

endmodule

// File: doc/ddr_rd_demux.md
# ddr_rd_demux

Write-back stage directly downstream of the memory controller's DDR read path. It accepts a burst descriptor (SRAM base address, beat count, valid-lane count of the final beat, last-chunk flag) and then the DDR read-data beats. It scatters each 16-byte beat byte-per-bank across the 16 SRAM banks and pulses a completion strobe when the burst has been written.

## Interface
- NUM_BANKS, 16: SRAM banks, equal to the bytes per DDR beat
- ADDR_W, 19: SRAM address width
- LEN_W, 8: width of the beat-count field
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  descriptor strobe; accepted only in IDLE
- base_addr  in  ADDR_W  SRAM address of beat 0, identical for all banks
- len_beats  in  LEN_W  beats in the burst; 0 is treated as 1
- num_last_valid  in  4  valid lanes in the final beat, minus 1 (0 means lane 0 only, 15 means all lanes)
- last_in  in  1  burst is the final chunk of the job; echoed on completion
- ddr_rvalid  in  1  DDR read beat valid
- ddr_rdata  in  8*NUM_BANKS  beat data; byte i goes to bank i
- ddr_rready  out  1  stage can accept a beat
- sram_we  out  NUM_BANKS  per-bank write enable
- sram_addr  out  NUM_BANKS*ADDR_W  per-bank write address
- sram_wdata  out  NUM_BANKS*8  per-bank write byte
- busy  out  1  a descriptor has been accepted and is not yet complete
- done  out  1  one-cycle completion pulse
- done_last  out  1  latched last_in; valid only while done=1, otherwise 0

## Operation
- FSM states:
  - IDLE to RECV on start. In the same edge, latch base_addr, len_beats (0 becomes 1), num_last_valid and last_in, and clear beat_cnt.
  - RECV to FLUSH on the edge that accepts the final beat (beat_cnt == len-1).
  - FLUSH to IDLE after one cycle. done=1 during FLUSH.
- ddr_rready = (state == RECV). A beat is accepted on any edge where ddr_rvalid && ddr_rready. Beats presented outside RECV are neither consumed nor written.
- For an accepted beat k:
  - Every bank i is registered with sram_addr[i] = (base + k) mod 2^ADDR_W and sram_wdata[i] = ddr_rdata[8i+7:8i].
  - sram_we[i] = 1 for all i, except on the final beat, where sram_we[i] = (i <= num_last_valid).
- Cycles in RECV with ddr_rvalid=0 (bubbles) write nothing: sram_we=0 and sram_addr/sram_wdata hold their previous values. Bubbles do not advance beat_cnt.
- Address arithmetic uses ADDR_W bits and wraps silently. Base 0x7FFFF with 2 beats writes 0x7FFFF, then 0x00000.
- start while busy is ignored; no queueing.
- busy = (state != IDLE).
- Reset at any point, including mid-burst: state IDLE, beat_cnt 0, all outputs 0, and the partial burst is abandoned with no done pulse.

## Timing
- Reset values: ddr_rready 0, sram_we 0, sram_addr 0, sram_wdata 0, busy 0, done 0, done_last 0.
- start accepted at edge T. busy and ddr_rready are 1 from T+1.
- A beat accepted at edge T appears on the SRAM outputs during cycle T+1, giving 1-cycle registered latency. sram_we is a single-cycle pulse per beat.
- Throughput: one beat per cycle when ddr_rvalid is held high.
- Final beat accepted at edge T:
  - ddr_rready=0 from T+1.
  - The final SRAM write and done=1 both occur in cycle T+1.
  - IDLE from T+2, so the next start is accepted no earlier than edge T+2.
- Minimum descriptor-to-done: 2 cycles after start for a 1-beat burst with rvalid already high.
- start asserted in the same cycle as the final beat is ignored, because state is still RECV.

## Test plan
- Single beat, all lanes:
  - Stimulus: base 0x00100, len 1, num_last_valid 15, last_in 1, rdata 0x0F0E…0100.
  - Response: one cycle with sram_we=0xFFFF, all addresses 0x00100, bank i wdata = i.
  - Response: done=1 and done_last=1 in the same cycle.
- 4-beat back-to-back with partial tail:
  - Stimulus: base 0x00200, num_last_valid 3, last_in 0.
  - Response: addresses 0x200–0x203 in 4 consecutive cycles.
  - Response: sram_we on the last beat is 0x000F, done_last=0.
- Bubbles:
  - Stimulus: 3-beat burst with ddr_rvalid pattern 1,0,0,1,0,1.
  - Response: exactly 3 write pulses at addresses base, base+1, base+2.
  - Response: done 1 cycle after the third acceptance.
- Wrap and len 0:
  - Stimulus: base 0x7FFFF, len 2. Response: writes to 0x7FFFF then 0x00000.
  - Stimulus: a separate burst with len 0. Response: behaves as 1 beat.
- Ignored start plus reset:
  - Stimulus: second start mid-burst. Response: no effect on the burst.
  - Stimulus: rst_n asserted after beat 2 of 5. Response: all outputs 0 immediately, no done.
  - Stimulus: new start after release. Response: a fresh burst completes normally.
